// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: architectural constants and the fetch FSM state type.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDrop
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_rvalid, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_rvalid, output imem_rdata);

endinterface

// File: rtl/fetch_buf.sv
// One-entry holding register for the fetched instruction presented to IF/ID.
module fetch_buf
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  input  logic        consume,
  input  logic        flush,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  // flush beats load beats consume; pc is left alone when emptying
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= NOP_INST;
    end else if (flush) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      inst  <= load_inst;
    end else if (consume) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight and buffers
// one instruction for IF/ID, dropping responses made stale by a redirect.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  fetch_unit_if.master        imem,
  output logic                f_valid,
  output logic [31:0]         f_pc,
  output logic [31:0]         f_inst
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  req_pc_q;
  logic         consume;
  logic         issue;
  logic         resp;

  assign consume = f_valid & ~stall;
  // Only issue when the buffer will be free, so a wanted response can always be loaded
  assign issue   = (state_q == StIdle) & ~redirect & (~f_valid | consume);
  assign resp    = (state_q == StWait) & imem.imem_rvalid & ~redirect;

  assign imem.imem_req  = rst & issue;
  assign imem.imem_addr = pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else if (redirect) begin
      pc_q <= redirect_pc & ~32'd3;
      if (state_q != StIdle && !imem.imem_rvalid) begin
        state_q <= StDrop;
      end else begin
        state_q <= StIdle;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (issue) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + 32'd4;
            state_q  <= StWait;
          end
        end
        StWait, StDrop: begin
          if (imem.imem_rvalid) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  fetch_buf #(
    .NOP_INST (NOP_INST)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (resp),
    .load_pc   (req_pc_q),
    .load_inst (imem.imem_rdata),
    .consume   (consume),
    .flush     (redirect),
    .valid     (f_valid),
    .pc        (f_pc),
    .inst      (f_inst)
  );

  // A response with nothing outstanding is a memory protocol error; the FSM ignores it
  rvalid_in_idle : assert property (@(posedge clk) disable iff (!rst)
      !(state_q == StIdle && imem.imem_rvalid))
    else $warning("imem_rvalid with no request outstanding (ignored)");

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized
// stall/redirect/latency traffic, checked against a transaction-level model.
module tb_fetch_unit;

  localparam logic [31:0] Nop  = 32'h0000_0013;
  localparam logic [31:0] Salt = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_inst;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus.master),
    .f_valid     (f_valid),
    .f_pc        (f_pc),
    .f_inst      (f_inst)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: fetch pointer, one in-flight request (wanted or not), one buffer slot
  logic [31:0] m_pc, m_req_pc, b_pc, b_inst;
  logic        m_busy, m_keep, b_valid;

  // Memory environment: at most one pending response, counted down in cycles
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          lat;
  logic        rand_lat;

  logic [31:0] issued[$];
  logic        last_req, obs_valid;
  logic [31:0] obs_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_req_pc = 32'h0; m_busy = 1'b0; m_keep = 1'b0;
    b_valid = 1'b0; b_pc = 32'h0; b_inst = Nop;
  endtask

  // One clock cycle: drive at negedge, check request mid-cycle, check buffer after the edge
  task automatic cyc(input logic s, input logic r, input logic [31:0] rpc);
    logic        exp_req, rv, req_seen;
    logic [31:0] rd, addr_seen;
    stall = s; redirect = r; redirect_pc = rpc;
    rv = mem_busy && (mem_cnt == 0);
    rd = rv ? (mem_addr ^ Salt) : $urandom;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    #1;
    if (!rst) model_reset();
    exp_req = rst && !m_busy && !r && (!b_valid || !s);
    check("imem_req", {31'b0, bus.imem_req}, {31'b0, exp_req});
    if (exp_req) check("imem_addr", bus.imem_addr, m_pc);
    req_seen  = bus.imem_req;
    addr_seen = bus.imem_addr;
    if (req_seen) issued.push_back(addr_seen);
    last_req = req_seen;
    @(posedge clk);
    if (rst) begin
      if (r) begin
        m_pc = rpc & ~32'd3;
        b_valid = 1'b0; b_inst = Nop;
        if (m_busy && rv) m_busy = 1'b0;
        else if (m_busy)  m_keep = 1'b0;
      end else begin
        if (b_valid && !s) begin b_valid = 1'b0; b_inst = Nop; end
        if (m_busy && rv) begin
          if (m_keep) begin b_valid = 1'b1; b_pc = m_req_pc; b_inst = rd; end
          m_busy = 1'b0;
        end
        if (exp_req) begin
          m_req_pc = m_pc; m_pc = m_pc + 32'd4; m_busy = 1'b1; m_keep = 1'b1;
        end
      end
    end
    if (rv) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (req_seen) begin
      mem_busy = 1'b1;
      mem_addr = addr_seen;
      mem_cnt  = rand_lat ? int'($urandom_range(0, 3)) : lat - 1;
    end
    #1;
    check("f_valid", {31'b0, f_valid}, {31'b0, b_valid});
    check("f_inst", f_inst, b_inst);
    if (b_valid) check("f_pc", f_pc, b_pc);
    obs_valid = f_valid;
    obs_pc    = f_pc;
    @(negedge clk);
  endtask

  initial begin
    int          n0;
    logic        got;
    logic [31:0] first_pc;
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    mem_busy = 1'b0; mem_addr = '0; mem_cnt = 0; lat = 1; rand_lat = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset state
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    check("rst_f_pc", f_pc, 32'h0);
    check("rst_f_inst", f_inst, Nop);

    // Streaming with 1-cycle memory
    rst = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 32'h0);
    check("seq_addr0", issued[0], 32'h0);
    check("seq_addr1", issued[1], 32'h4);
    check("seq_addr2", issued[2], 32'h8);

    // Stall held three cycles over a valid instruction
    for (int i = 0; i < 6 && !b_valid; i++) cyc(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0);

    // Redirect the cycle after a 3-cycle request is issued
    lat = 3;
    for (int i = 0; i < 8 && !last_req; i++) cyc(1'b0, 1'b0, 32'h0);
    n0 = issued.size();
    cyc(1'b0, 1'b1, 32'h100);
    got = 1'b0; first_pc = 'x;
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 1'b0, 32'h0);
      if (obs_valid && !got) begin got = 1'b1; first_pc = obs_pc; end
    end
    check("redir_addr", issued[n0], 32'h100);
    check("redir_first_pc", first_pc, 32'h100);

    // Redirect coinciding with a response, unaligned target
    lat = 1;
    for (int i = 0; i < 8 && !(mem_busy && mem_cnt == 0); i++) cyc(1'b0, 1'b0, 32'h0);
    n0 = issued.size();
    cyc(1'b0, 1'b1, 32'h203);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 32'h0);
    check("redir_align", issued[n0], 32'h200);

    // Redirect while stalled with a valid instruction
    for (int i = 0; i < 6 && !b_valid; i++) cyc(1'b0, 1'b0, 32'h0);
    n0 = issued.size();
    cyc(1'b1, 1'b1, 32'h400);
    check("stall_redir_inst", f_inst, Nop);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 32'h0);
    check("stall_redir_addr", issued[n0], 32'h400);

    // Reset mid-request; the stale response lands in the first cycle after release
    lat = 2;
    for (int i = 0; i < 8 && !last_req; i++) cyc(1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 32'h0);
    check("midrst_f_valid", {31'b0, f_valid}, 32'h0);
    check("midrst_f_pc", f_pc, 32'h0);
    rst = 1'b1;
    n0 = issued.size();
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 32'h0);
    check("midrst_addr", issued[n0], 32'h0);

    // Randomized traffic
    rand_lat = 1'b1;
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom);
    end
    cyc(1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
